// File: rtl/ff_actn_gatherer.sv
// Serial-to-parallel gatherer: packs fi beats of z/fi actn/sp values into one
// z-wide package. Two ping-pong buffers let the producer stream without bubbles.
module ff_actn_gatherer #(
    parameter int unsigned fi    = 4,
    parameter int unsigned z     = 8,
    parameter int unsigned width = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [width*z/fi-1:0]     sigmoid_package,
    input  logic [width*z/fi-1:0]     sp_package,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [width*z-1:0]        actn_package,
    output logic [width*z-1:0]        sp_out_package,
    output logic [$clog2(fi)-1:0]     beat_cnt
);

    localparam int unsigned LANES  = z / fi;
    localparam int unsigned BEAT_W = width * LANES;
    localparam int unsigned PKG_W  = width * z;
    localparam int unsigned CNT_W  = $clog2(fi);

    logic [PKG_W-1:0] actn_buf [2];
    logic [PKG_W-1:0] sp_buf   [2];
    logic [1:0]       full;
    logic             wp;
    logic             rp;
    logic [CNT_W-1:0] bc;

    logic             accept;
    logic             drain;
    logic             last_beat;
    int unsigned      wr_base;

    assign in_ready       = !full[wp];
    assign out_valid      = full[rp];
    assign actn_package   = actn_buf[rp];
    assign sp_out_package = sp_buf[rp];
    assign beat_cnt       = bc;

    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign last_beat = (bc == CNT_W'(fi - 1));
    assign wr_base   = 32'(bc) * BEAT_W;

    // Accept and drain never collide on one flag: when wp==rp a full buffer
    // blocks accept, so they touch full[] at different indices.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                actn_buf[i] <= '0;
                sp_buf[i]   <= '0;
            end
            full <= '0;
            wp   <= 1'b0;
            rp   <= 1'b0;
            bc   <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < 2; i++) begin
                actn_buf[i] <= '0;
                sp_buf[i]   <= '0;
            end
            full <= '0;
            wp   <= 1'b0;
            rp   <= 1'b0;
            bc   <= '0;
        end else begin
            if (accept) begin
                actn_buf[wp][wr_base +: BEAT_W] <= sigmoid_package;
                sp_buf[wp][wr_base +: BEAT_W]   <= sp_package;
                if (last_beat) begin
                    full[wp] <= 1'b1;
                    wp       <= ~wp;
                    bc       <= '0;
                end else begin
                    bc <= bc + 1'b1;
                end
            end
            if (drain) begin
                full[rp] <= 1'b0;
                rp       <= ~rp;
            end
        end
    end

endmodule

// File: tb/tb_ff_actn_gatherer.sv
// Self-checking bench for ff_actn_gatherer (fi=4, z=8, width=16): directed
// scenarios plus random traffic against a queue-based package model.
module tb_ff_actn_gatherer;

    localparam int FI    = 4;
    localparam int Z     = 8;
    localparam int W     = 16;
    localparam int LANES = Z / FI;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  sigmoid_package = '0;
    logic [31:0]  sp_package = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] actn_package;
    logic [127:0] sp_out_package;
    logic [1:0]   beat_cnt;

    ff_actn_gatherer #(.fi(FI), .z(Z), .width(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clear(clear),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .sigmoid_package(sigmoid_package),
        .sp_package(sp_package),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .actn_package(actn_package),
        .sp_out_package(sp_out_package),
        .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: values of the package being gathered, and the FIFO of
    // completed packages awaiting drain (at most two fit).
    logic [15:0]  pa[$];
    logic [15:0]  ps[$];
    logic [127:0] qa[$];
    logic [127:0] qs[$];

    int checks = 0;
    int errors = 0;
    int seq = 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pa.delete(); ps.delete(); qa.delete(); qs.delete();
    endtask

    task automatic check_outputs(input string where);
        chk({where, ":in_ready"}, 128'(in_ready), 128'(qa.size() < 2));
        chk({where, ":out_valid"}, 128'(out_valid), 128'(qa.size() > 0));
        chk({where, ":beat_cnt"}, 128'(beat_cnt), 128'(pa.size() / LANES));
        if (qa.size() > 0) begin
            chk({where, ":actn"}, actn_package, qa[0]);
            chk({where, ":sp"}, sp_out_package, qs[0]);
        end
    endtask

    task automatic check_zero(input string where);
        chk({where, ":out_valid"}, 128'(out_valid), 128'(0));
        chk({where, ":in_ready"}, 128'(in_ready), 128'(1));
        chk({where, ":beat_cnt"}, 128'(beat_cnt), 128'(0));
        chk({where, ":actn"}, actn_package, 128'(0));
        chk({where, ":sp"}, sp_out_package, 128'(0));
    endtask

    // One clock cycle: drive, check pre-edge state, clock, advance model.
    task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] s,
                         input logic ordy, input logic clr, input string where,
                         output logic acc);
        logic         drn;
        logic [127:0] pka;
        logic [127:0] pks;
        in_valid = iv; sigmoid_package = a; sp_package = s;
        out_ready = ordy; clear = clr;
        #1 check_outputs(where);
        acc = iv && (qa.size() < 2);
        drn = ordy && (qa.size() > 0);
        @(posedge clk);
        if (clr) begin
            model_reset();
            acc = 1'b0;
        end else begin
            if (drn) begin
                void'(qa.pop_front());
                void'(qs.pop_front());
            end
            if (acc) begin
                for (int j = 0; j < LANES; j++) begin
                    pa.push_back(a[16*j +: 16]);
                    ps.push_back(s[16*j +: 16]);
                end
                if (pa.size() == Z) begin
                    for (int k = 0; k < Z; k++) begin
                        pka[16*k +: 16] = pa[k];
                        pks[16*k +: 16] = ps[k];
                    end
                    qa.push_back(pka);
                    qs.push_back(pks);
                    pa.delete(); ps.delete();
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0; clear = 1'b0;
    endtask

    // Sequential beat: lane values seq, seq+1; sp = 0x100 + value.
    task automatic seq_cycle(input logic iv, input logic ordy, input string where,
                             output logic acc);
        logic [31:0] a;
        logic [31:0] s;
        a = {16'(seq + 1), 16'(seq)};
        s = {16'(seq + 1 + 'h100), 16'(seq + 'h100)};
        cycle(iv, a, s, ordy, 1'b0, where, acc);
        if (acc) seq += LANES;
    endtask

    initial begin
        logic         acc;
        logic [127:0] held;
        int           accepted;

        // 1: asynchronous reset takes effect without a clock edge
        #2 reset_n = 1'b0;
        #1 check_zero("t1_reset");
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();

        // 2: four beats with out_ready=1 form package 1..8
        seq = 1;
        for (int b = 0; b < 4; b++) seq_cycle(1'b1, 1'b1, "t2_fill", acc);
        chk("t2_out_valid", 128'(out_valid), 128'(1));
        chk("t2_actn", actn_package,
            {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1});
        chk("t2_sp", sp_out_package,
            {16'h108, 16'h107, 16'h106, 16'h105, 16'h104, 16'h103, 16'h102, 16'h101});
        seq_cycle(1'b0, 1'b1, "t2_drain", acc);

        // 3: 12 beats against a stalled consumer, then release
        seq = 1;
        accepted = 0;
        for (int c = 0; c < 12; c++) begin
            seq_cycle(1'b1, 1'b0, "t3_stall", acc);
            if (acc) accepted++;
        end
        chk("t3_accepted_while_stalled", 128'(accepted), 128'(8));
        chk("t3_in_ready_low", 128'(in_ready), 128'(0));
        for (int c = 0; c < 20 && accepted < 12; c++) begin
            seq_cycle(1'b1, 1'b1, "t3_resume", acc);
            if (acc) accepted++;
        end
        chk("t3_accepted_total", 128'(accepted), 128'(12));
        for (int c = 0; c < 4; c++) seq_cycle(1'b0, 1'b1, "t3_drain", acc);
        chk("t3_empty", 128'(out_valid), 128'(0));

        // 4: package held stable under back-pressure
        for (int b = 0; b < 4; b++) seq_cycle(1'b1, 1'b0, "t4_fill", acc);
        held = actn_package;
        for (int c = 0; c < 5; c++) begin
            seq_cycle(1'b0, 1'b0, "t4_hold", acc);
            chk("t4_actn_stable", actn_package, held);
            chk("t4_valid_held", 128'(out_valid), 128'(1));
        end

        // 5: clear with package 1 pending and package 2 half-filled
        seq_cycle(1'b1, 1'b0, "t5_p2", acc);
        seq_cycle(1'b1, 1'b0, "t5_p2", acc);
        cycle(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b1, "t5_clear", acc);
        check_zero("t5_after_clear");
        seq = 101;
        for (int b = 0; b < 4; b++) seq_cycle(1'b1, 1'b0, "t5_refill", acc);
        chk("t5_sole_pkg", actn_package,
            {16'd108, 16'd107, 16'd106, 16'd105, 16'd104, 16'd103, 16'd102, 16'd101});
        seq_cycle(1'b0, 1'b1, "t5_drain", acc);
        chk("t5_sole_only", 128'(out_valid), 128'(0));

        // 6: reset pulse mid-package
        seq_cycle(1'b1, 1'b0, "t6_beat", acc);
        seq_cycle(1'b1, 1'b0, "t6_beat", acc);
        reset_n = 1'b0;
        #1 check_zero("t6_reset");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        seq = 201;
        for (int b = 0; b < 4; b++) seq_cycle(1'b1, 1'b0, "t6_refill", acc);
        chk("t6_clean_pkg", actn_package,
            {16'd208, 16'd207, 16'd206, 16'd205, 16'd204, 16'd203, 16'd202, 16'd201});
        seq_cycle(1'b0, 1'b1, "t6_drain", acc);

        // Random traffic with occasional clears
        for (int c = 0; c < 400; c++) begin
            cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 59) == 0),
                  "rand", acc);
        end

        // Full-throughput streaming: one beat per cycle, no bubbles
        accepted = 0;
        for (int c = 0; c < 16; c++) begin
            cycle(1'b1, $urandom, $urandom, 1'b1, 1'b0, "stream", acc);
            if (acc) accepted++;
        end
        chk("stream_no_bubble", 128'(accepted), 128'(16));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
